// File: rtl/mismatch_scoreboard.sv
// Synthesizable compare scoreboard: counts accepted samples and masked mismatches
// between a reference output and a DUT output, and latches the first mismatch index.
module mismatch_scoreboard #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] ref_out,
  input  logic [WIDTH-1:0] dut_out,
  input  logic [WIDTH-1:0] care_mask,
  input  logic             finish,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] err_bits_seen,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_samples, w_samples_d;
  logic [CNT_W-1:0] r_errors, w_errors_d;
  logic [CNT_W-1:0] r_idx, w_idx_d;
  logic             r_fev, w_fev_d;
  logic [WIDTH-1:0] r_bits, w_bits_d;
  logic             r_busy, r_done, r_pass;

  logic [WIDTH-1:0] w_mism_vec;
  logic             w_mismatch;
  logic             w_accept;

  assign w_mism_vec = (ref_out ^ dut_out) & care_mask;
  assign w_mismatch = |w_mism_vec;
  assign w_accept   = (r_state == StRun) && sample_valid && !start;

  always_comb begin
    w_state_d = r_state;
    if (start) begin
      w_state_d = StRun;
    end else if (r_state == StRun && finish) begin
      w_state_d = StDone;
    end
  end

  always_comb begin
    w_samples_d = r_samples;
    w_errors_d  = r_errors;
    w_idx_d     = r_idx;
    w_fev_d     = r_fev;
    w_bits_d    = r_bits;
    if (start) begin
      w_samples_d = '0;
      w_errors_d  = '0;
      w_idx_d     = '0;
      w_fev_d     = 1'b0;
      w_bits_d    = '0;
    end else if (w_accept) begin
      // Counters saturate at all-ones instead of wrapping.
      if (r_samples != {CNT_W{1'b1}}) w_samples_d = r_samples + 1'b1;
      if (w_mismatch) begin
        if (r_errors != {CNT_W{1'b1}}) w_errors_d = r_errors + 1'b1;
        w_bits_d = r_bits | w_mism_vec;
        if (!r_fev) begin
          w_idx_d = r_samples;
          w_fev_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state   <= StIdle;
      r_samples <= '0;
      r_errors  <= '0;
      r_idx     <= '0;
      r_fev     <= 1'b0;
      r_bits    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_samples <= w_samples_d;
      r_errors  <= w_errors_d;
      r_idx     <= w_idx_d;
      r_fev     <= w_fev_d;
      r_bits    <= w_bits_d;
      r_busy    <= (w_state_d == StRun);
      r_done    <= (w_state_d == StDone);
      r_pass    <= (w_state_d == StDone) && (w_errors_d == '0);
    end
  end

  assign samples         = r_samples;
  assign errors          = r_errors;
  assign first_err_idx   = r_idx;
  assign first_err_valid = r_fev;
  assign err_bits_seen   = r_bits;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;

endmodule

// File: tb/tb_mismatch_scoreboard.sv
// Directed, table-driven bench for mismatch_scoreboard: a 4-bit instance for the
// functional vectors and a 1-bit, 3-bit-counter instance for saturation.
module tb_mismatch_scoreboard;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, CNT_W=8
  logic       a_start, a_valid, a_finish;
  logic [3:0] a_ref, a_dut, a_mask;
  logic [7:0] a_samples, a_errors, a_idx;
  logic       a_fev, a_busy, a_done, a_pass;
  logic [3:0] a_bits;

  // Instance B: WIDTH=1, CNT_W=3
  logic       b_start, b_valid, b_finish, b_ref, b_dut, b_mask;
  logic [2:0] b_samples, b_errors, b_idx;
  logic       b_fev, b_bits, b_busy, b_done, b_pass;

  mismatch_scoreboard #(.WIDTH(4), .CNT_W(8)) u_a (
    .clk(clk), .areset(areset), .start(a_start), .sample_valid(a_valid),
    .ref_out(a_ref), .dut_out(a_dut), .care_mask(a_mask), .finish(a_finish),
    .samples(a_samples), .errors(a_errors), .first_err_idx(a_idx),
    .first_err_valid(a_fev), .err_bits_seen(a_bits), .busy(a_busy),
    .done(a_done), .pass(a_pass)
  );

  mismatch_scoreboard #(.WIDTH(1), .CNT_W(3)) u_b (
    .clk(clk), .areset(areset), .start(b_start), .sample_valid(b_valid),
    .ref_out(b_ref), .dut_out(b_dut), .care_mask(b_mask), .finish(b_finish),
    .samples(b_samples), .errors(b_errors), .first_err_idx(b_idx),
    .first_err_valid(b_fev), .err_bits_seen(b_bits), .busy(b_busy),
    .done(b_done), .pass(b_pass)
  );

  typedef struct {
    logic       st, vl, fn;
    logic [3:0] rf, du, mk;
    logic [7:0] es, ee, ei;
    logic       ef;
    logic [3:0] eb;
    logic       ebusy, edone, epass;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mkv(logic st, logic vl, logic fn, logic [3:0] rf, logic [3:0] du,
                               logic [3:0] mk, logic [7:0] es, logic [7:0] ee, logic [7:0] ei,
                               logic ef, logic [3:0] eb, logic ebusy, logic edone,
                               logic epass);
    vec_t v;
    v.st = st; v.vl = vl; v.fn = fn; v.rf = rf; v.du = du; v.mk = mk;
    v.es = es; v.ee = ee; v.ei = ei; v.ef = ef; v.eb = eb;
    v.ebusy = ebusy; v.edone = edone; v.epass = epass;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] es, input logic [7:0] ee,
                       input logic [7:0] ei, input logic ef, input logic [3:0] eb,
                       input logic ebusy, input logic edone, input logic epass);
    chk({tag, ".samples"}, 32'(a_samples), 32'(es));
    chk({tag, ".errors"}, 32'(a_errors), 32'(ee));
    chk({tag, ".first_err_idx"}, 32'(a_idx), 32'(ei));
    chk({tag, ".first_err_valid"}, 32'(a_fev), 32'(ef));
    chk({tag, ".err_bits_seen"}, 32'(a_bits), 32'(eb));
    chk({tag, ".busy"}, 32'(a_busy), 32'(ebusy));
    chk({tag, ".done"}, 32'(a_done), 32'(edone));
    chk({tag, ".pass"}, 32'(a_pass), 32'(epass));
  endtask

  task automatic a_idle_inputs();
    a_start = 0; a_valid = 0; a_finish = 0; a_ref = 0; a_dut = 0; a_mask = 0;
  endtask

  initial begin
    // NOR sweep: ref = dut = 1,0,0,0 with mask bit 0
    vecs.push_back(mkv(1,0,0, 0,0,0,  0,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,1,0, 1,1,1,  1,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,1,0, 0,0,1,  2,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,1,0, 0,0,1,  3,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,1,0, 0,0,1,  4,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,0,1, 0,0,1,  4,0,0,0,0, 0,1,1));
    vecs.push_back(mkv(0,1,1, 1,0,1,  4,0,0,0,0, 0,1,1));  // ignored in DONE
    // First-error index: mismatches on samples 3 and 7
    vecs.push_back(mkv(1,0,0, 0,0,0,  0,0,0,0,0, 1,0,0));
    for (int k = 0; k < 10; k++) begin
      logic       inv;
      logic [7:0] ee;
      inv = (k == 3) || (k == 7);
      ee  = (k >= 7) ? 8'd2 : (k >= 3) ? 8'd1 : 8'd0;
      vecs.push_back(mkv(0,1,0, 4'd1, inv ? 4'd0 : 4'd1, 4'd1, 8'(k + 1), ee,
                         (k >= 3) ? 8'd3 : 8'd0, k >= 3, (k >= 3) ? 4'd1 : 4'd0, 1,0,0));
    end
    vecs.push_back(mkv(0,0,1, 0,0,0,  10,2,3,1,1, 0,1,0));
    // Don't-care masking
    vecs.push_back(mkv(1,0,0, 0,0,0,  0,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,1,0, 4'b1010,4'b0010,4'b0111, 1,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,1,0, 4'b1010,4'b0010,4'b1111, 2,1,1,1,4'b1000, 1,0,0));
    vecs.push_back(mkv(0,1,0, 4'b1111,4'b0000,4'b0000, 3,1,1,1,4'b1000, 1,0,0));
    // start + sample is dropped, finish + mismatching sample is counted
    vecs.push_back(mkv(1,1,0, 4'b1111,4'b0000,4'b1111, 0,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,1,1, 4'b1010,4'b0010,4'b1111, 1,1,0,1,4'b1000, 0,1,0));
    // start + finish + sample on one edge: RUN, all clear
    vecs.push_back(mkv(1,1,1, 4'b1111,4'b0000,4'b1111, 0,0,0,0,0, 1,0,0));
    vecs.push_back(mkv(0,0,1, 0,0,0,  0,0,0,0,0, 0,1,1));

    areset = 1;
    a_idle_inputs();
    b_start = 0; b_valid = 0; b_finish = 0; b_ref = 0; b_dut = 0; b_mask = 0;
    #12;
    chk_a("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.b_samples", 32'(b_samples), 0);
    areset = 0;
    step();

    foreach (vecs[i]) begin
      a_start = vecs[i].st; a_valid = vecs[i].vl; a_finish = vecs[i].fn;
      a_ref = vecs[i].rf; a_dut = vecs[i].du; a_mask = vecs[i].mk;
      step();
      chk_a($sformatf("vec%0d", i), vecs[i].es, vecs[i].ee, vecs[i].ei, vecs[i].ef,
            vecs[i].eb, vecs[i].ebusy, vecs[i].edone, vecs[i].epass);
    end
    a_idle_inputs();

    // Saturation on 3-bit counters: 9 mismatches
    b_start = 1; step(); b_start = 0;
    b_valid = 1; b_ref = 1; b_dut = 0; b_mask = 1;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 6) chk("sat.samples_at7", 32'(b_samples), 7);
    end
    b_valid = 0;
    chk("sat.samples", 32'(b_samples), 7);
    chk("sat.errors", 32'(b_errors), 7);
    chk("sat.first_err_idx", 32'(b_idx), 0);
    chk("sat.first_err_valid", 32'(b_fev), 1);
    chk("sat.err_bits", 32'(b_bits), 1);
    b_finish = 1; step(); b_finish = 0;
    chk("sat.done", 32'(b_done), 1);
    chk("sat.pass", 32'(b_pass), 0);

    // Async reset mid-RUN after 5 mismatching samples
    a_start = 1; step(); a_start = 0;
    a_valid = 1; a_ref = 4'b0001; a_dut = 4'b0000; a_mask = 4'b0001;
    repeat (5) step();
    chk_a("pre_reset", 5, 5, 0, 1, 1, 1, 0, 0);
    #2 areset = 1;
    #1;
    chk_a("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("async_reset.b_done", 32'(b_done), 0);
    @(negedge clk);
    areset = 0;
    a_finish = 1;
    repeat (3) step();
    chk_a("idle_ignores", 0, 0, 0, 0, 0, 0, 0, 0);
    a_idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
